// File: rtl/fpu_fmul.sv
// fpu_fmul: single-precision (binary32) multiplier with one output register.
// Denormal operands are flushed to zero, NaN is not propagated, and the
// product is rounded to nearest with ties away from zero. Latency is one
// clock with a throughput of one operation per cycle.
module fpu_fmul (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] res,
  output logic        valid_out
);

  logic        sign;
  logic [7:0]  ex;
  logic [7:0]  ey;
  logic        zero_in;
  logic        inf_in;
  logic [47:0] prod;
  logic        norm;
  logic [22:0] kept;
  logic        rbit;
  logic [23:0] rounded;
  logic [9:0]  exp_sum;
  logic [31:0] res_next;

  assign sign    = x[31] ^ y[31];
  assign ex      = x[30:23];
  assign ey      = y[30:23];
  // Exponent 0 covers both true zero and flushed denormals.
  assign zero_in = (ex == 8'd0) || (ey == 8'd0);
  assign inf_in  = (ex == 8'hFF) || (ey == 8'hFF);

  // Full 48-bit product of the mantissas with the hidden one restored.
  assign prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};

  // A product in [2,4) sets bit 47 and needs a one-place right shift.
  assign norm = prod[47];
  assign kept = norm ? prod[46:24] : prod[45:23];
  assign rbit = norm ? prod[23]    : prod[22];

  // Adding the round bit; a carry into bit 23 leaves the low bits at zero,
  // which is exactly the renormalised mantissa 1.0.
  assign rounded = {1'b0, kept} + {23'd0, rbit};

  // Biased exponent in 10-bit two's complement so that under- and overflow
  // remain visible (range is -125 .. 383).
  assign exp_sum = {2'b00, ex} + {2'b00, ey} - 10'd127
                 + {9'd0, norm} + {9'd0, rounded[23]};

  // Special-case selection followed by the normal packed result.
  always_comb begin
    res_next = {sign, exp_sum[7:0], rounded[22:0]};
    if (zero_in) begin
      res_next = {sign, 31'd0};
    end else if (inf_in) begin
      res_next = {sign, 8'hFF, 23'd0};
    end else if ($signed(exp_sum) <= $signed(10'sd0)) begin
      res_next = {sign, 31'd0};
    end else if ($signed(exp_sum) >= $signed(10'sd255)) begin
      res_next = {sign, 8'hFF, 23'd0};
    end
  end

  // Output register: result captured every cycle, qualified by valid_out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res       <= 32'd0;
      valid_out <= 1'b0;
    end else begin
      res       <= res_next;
      valid_out <= valid_in;
    end
  end

endmodule

// File: tb/tb_fpu_fmul.sv
// Testbench for fpu_fmul: directed vector table with exact expectations,
// a randomised sweep checked against a real-valued reference product, and
// an asynchronous reset applied mid-stream. A scoreboard queue carries the
// expectation of each issued operation to the cycle its result appears.
module tb_fpu_fmul;

  logic        clk;
  logic        rstn;
  logic        valid_in;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] res;
  logic        valid_out;

  int total;
  int bad;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    bit          exact;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[10];

  fpu_fmul dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .x         (x),
    .y         (y),
    .res       (res),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) begin
      for (int i = 0; i < n; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -n; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Decode binary32 with denormals treated as zero; infinities map to a
  // value far outside any bound used below.
  function automatic real to_real(input logic [31:0] v);
    real m;
    int  e;
    e = int'(v[30:23]);
    if (e == 0) return 0.0;
    if (e == 255) m = 1.0e300;
    else m = (1.0 + real'(int'(v[22:0])) / 8388608.0) * pow2(e - 127);
    return v[31] ? -m : m;
  endfunction

  task automatic check_result(input sb_t e);
    real p, ap, r, err, bound;
    if (e.exact) begin
      total++;
      if (res !== e.r) begin
        bad++;
        $display("FAIL exact %h*%h: got %h want %h", e.a, e.b, res, e.r);
      end else begin
        $display("ok   exact %h*%h = %h", e.a, e.b, res);
      end
    end else begin
      total++;
      if (res[31] !== (e.a[31] ^ e.b[31])) begin
        bad++;
        $display("FAIL sign %h*%h: got %h want sign %0b", e.a, e.b, res, e.a[31] ^ e.b[31]);
      end
      p  = to_real(e.a) * to_real(e.b);
      ap = (p < 0.0) ? -p : p;
      if (ap < pow2(127)) begin
        r   = to_real(res);
        err = (r > p) ? (r - p) : (p - r);
        total++;
        if (ap >= pow2(-126)) begin
          bound = ap * pow2(-24);
          if (err > bound) begin
            bad++;
            $display("FAIL accuracy %h*%h: got %h err %e want err<=%e", e.a, e.b, res, err, bound);
          end
        end else if (err >= pow2(-126)) begin
          bad++;
          $display("FAIL tiny %h*%h: got %h err %e want err<2^-126", e.a, e.b, res, err);
        end
      end else if (ap >= pow2(128)) begin
        total++;
        if (res[30:0] !== 31'h7F800000) begin
          bad++;
          $display("FAIL overflow %h*%h: got %h want infinity", e.a, e.b, res);
        end
      end
    end
  endtask

  // Monitor: one transaction checked per valid output, just after the edge.
  always @(posedge clk) begin
    #1;
    if (rstn && valid_out) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid_out=1 res=%h want no result", res);
      end else begin
        check_result(sbq.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input bit exact, input logic [31:0] r);
    sb_t e;
    @(negedge clk);
    valid_in = v;
    x        = a;
    y        = b;
    if (v) begin
      e.a = a; e.b = b; e.r = r; e.exact = exact;
      sbq.push_back(e);
    end
  endtask

  function automatic logic [22:0] pick_mant();
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0: m = 23'h000000;
      1: m = 23'h000001;
      2: m = 23'h000002;
      3: m = 23'h380000;
      4: m = 23'h400000;
      5: m = 23'h5FFFFF;
      6: m = 23'h7FFFFF;
      default: m = 23'($urandom());
    endcase
    return m;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ea, eb;
    total    = 0;
    bad      = 0;
    rstn     = 1'b0;
    valid_in = 1'b0;
    x        = 32'd0;
    y        = 32'd0;

    vecs[0] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[1] = '{32'h40000000, 32'hC0400000, 32'hC0C00000};
    vecs[2] = '{32'h00000000, 32'hBF800000, 32'h80000000};
    vecs[3] = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
    vecs[4] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE};
    vecs[5] = '{32'h00800000, 32'h00800000, 32'h00000000};
    vecs[6] = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[7] = '{32'h00000001, 32'h3F800000, 32'h00000000};
    vecs[8] = '{32'h7F800001, 32'h80000000, 32'h80000000};
    vecs[9] = '{32'hFF800000, 32'h3F800000, 32'hFF800000};

    // Reset state
    #12;
    total++;
    if (res !== 32'd0) begin
      bad++;
      $display("FAIL reset_res: got %h want 00000000", res);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %0b want 0", valid_out);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Directed table, back-to-back
    for (int i = 0; i < 10; i++) drive(1'b1, vecs[i].a, vecs[i].b, 1'b1, vecs[i].r);
    // Bubble: no result may appear for an idle cycle
    drive(1'b0, 32'h3F800000, 32'h40000000, 1'b1, 32'h0);
    drive(1'b1, 32'h40400000, 32'h40400000, 1'b1, 32'h41100000);

    // Exponent walk over 1..254 with all sign combinations
    for (int e = 1; e <= 254; e++) begin
      ea = 8'(e);
      eb = 8'(((e * 37) % 254) + 1);
      drive(1'b1, {1'($urandom()), ea, pick_mant()}, {1'($urandom()), eb, pick_mant()}, 1'b0, 32'h0);
    end
    // Random sweep, mostly around bias so products stay in range
    for (int n = 0; n < 2000; n++) begin
      ea = (n % 4 == 0) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(64, 190));
      eb = (n % 4 == 0) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(64, 190));
      drive(1'b1, {1'($urandom()), ea, pick_mant()}, {1'($urandom()), eb, pick_mant()}, 1'b0, 32'h0);
    end

    // Mid-stream asynchronous reset
    drive(1'b1, 32'h40000000, 32'h40000000, 1'b1, 32'h40800000);
    drive(1'b1, 32'h40400000, 32'h40000000, 1'b1, 32'h40C00000);
    #3;
    rstn     = 1'b0;
    valid_in = 1'b0;
    sbq.delete();
    #1;
    total++;
    if (res !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_res: got %h want 00000000", res);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_valid: got %0b want 0", valid_out);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 32'hBF800000, 32'h3FC00000, 1'b1, 32'hBFC00000);
    drive(1'b1, 32'h3F000000, 32'h3F000000, 1'b1, 32'h3E800000);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    repeat (4) @(negedge clk);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_fmul.md
# fpu_fmul

Single-precision (IEEE-754 binary32 format) floating-point multiplier for the FPU. It takes two operands, computes their product with one rounding step and registers the result. Latency is one clock and it accepts one operation per cycle. The FPU issue logic drives operands with a valid strobe and collects the result one cycle later.

## Interface
- Parameters: none.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- valid_in  input  1  the operands on x and y are valid this cycle.
- x  input  32  operand A: sign[31], exponent[30:23], mantissa[22:0].
- y  input  32  operand B, same format as x.
- res  output  32  registered product, binary32.
- valid_out  output  1  res holds the product of the operands presented one cycle earlier.

## Operation
Combinational datapath, followed by one output register.

- **Sign:** s = x[31] ^ y[31], in every case, including zero, underflow and infinity results.
- **Zero / denormal inputs:** an operand with exponent 0 is treated as zero (denormals are flushed). The result is then signed zero {s, 31'b0}. This takes priority over the infinity rule.
- **Exponent 255 inputs:** otherwise, an operand with exponent 255 gives signed infinity {s, 8'hFF, 23'b0}. NaN is not propagated.
- **Mantissa product:** for normal operands, form the full 48-bit product of the 24-bit mantissas with the hidden 1: {1, mx} × {1, my}.
- **Normalization:**
  - If product bit 47 is set, the kept mantissa is bits [46:24], the round bit is bit 23, and the exponent increments by 1.
  - Otherwise, the kept mantissa is bits [45:23] and the round bit is bit 22.
- **Rounding:** round to nearest, ties away from zero. Add the round bit to the 23-bit kept mantissa.
  - If this carries out, the mantissa becomes 0 and the exponent increments again.
- **Exponent:** E = ex + ey − 127 + normalization increment + rounding increment. Compute it in at least 10 signed bits so overflow and underflow are detectable.
  - E ≤ 0: flush to signed zero.
  - E ≥ 255: signed infinity.
  - Otherwise: res = {s, E[7:0], mantissa}.
- **Accuracy requirement:** for every pair of normal operands whose exact product P has |P| < 2^127, |res − P| < max(|P|·2^-22, 2^-126). Round-to-nearest gives a bound of 2^-24 relative, which meets this with margin.
- valid_out is a register copy of valid_in. res is captured every cycle regardless of valid_in; only valid_out qualifies it.

## Timing
- **Reset:** while rstn = 0 (asynchronous), res = 32'h0 and valid_out = 0.
- **Latency:** operands sampled at rising edge N produce res and valid_out at edge N. They are visible for the whole of cycle N+1.
- **Throughput:** one operation per cycle, back-to-back with no bubbles and no stall input.
- **Reset mid-operation:** any in-flight result is discarded. After reset deasserts, the first valid_out = 1 is for the first valid_in sampled.
- **Path depth:** the 24×24 multiply, normalization and rounding must close in one cycle at the FPU clock.

## Test plan
- **Identity:** x=3F800000, y=3F800000, valid_in=1 → next cycle res=3F800000, valid_out=1.
- **Signs and exactness:** 40000000 × C0400000 → C0C00000. Zero input: 00000000 × BF800000 → 80000000.
- **Rounding:** 3F800001 × 3F800001 → 3F800002. Max mantissa: 3FFFFFFF × 3FFFFFFF → 407FFFFE.
- **Boundaries:**
  - Underflow: 00800000 × 00800000 → 00000000.
  - Overflow: 7F000000 × 7F000000 → 7F800000.
  - Denormal input: 00000001 × 3F800000 → 00000000.
- **Sweep:** exponents 1..254 for each operand, all sign combinations, mantissas {0, 1, 2, 0x380000, 0x400000, 0x5FFFFF, 0x7FFFFF, random}. Every product with |P| < 2^127 meets the accuracy bound. Operands are streamed back-to-back, one per cycle.
- **Reset:** assert rstn=0 asynchronously mid-stream → res=0 and valid_out=0 immediately. After release, results resume with one-cycle latency.
